// File: rtl/sincronizador_filtro.sv
// sincronizador_filtro
// Multi-channel conditioner for asynchronous external lines (sensors,
// end-stop switches, push-buttons). Each channel passes through an
// N_ESTAGIOS flop synchroniser, then a counter-based debounce filter that
// only accepts a new level after it has persisted DEBOUNCE_CICLOS
// consecutive clocks, and finally produces registered rise/fall pulses
// coincident with the accepted level change.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst        asynchronous, active-high reset
//   signal_in  raw asynchronous inputs, one bit per channel
//   signal_out synchronised, debounced level (registered)
//   rise_pulse one-cycle pulse on each accepted 0->1 of signal_out
//   fall_pulse one-cycle pulse on each accepted 1->0 of signal_out
module sincronizador_filtro #(
  parameter int                  N_CANAIS        = 4,
  parameter int                  N_ESTAGIOS      = 2,
  parameter int                  DEBOUNCE_CICLOS = 4,
  parameter logic [N_CANAIS-1:0] VALOR_RESET     = {N_CANAIS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CANAIS-1:0] signal_in,
  output logic [N_CANAIS-1:0] signal_out,
  output logic [N_CANAIS-1:0] rise_pulse,
  output logic [N_CANAIS-1:0] fall_pulse
);

  localparam int CNT_W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if (N_ESTAGIOS < 2) begin : g_err_estagios
      $error("sincronizador_filtro: N_ESTAGIOS must be >= 2");
    end
    if (DEBOUNCE_CICLOS < 1) begin : g_err_debounce
      $error("sincronizador_filtro: DEBOUNCE_CICLOS must be >= 1");
    end
  endgenerate

  for (genvar c = 0; c < N_CANAIS; c++) begin : g_canal
    logic [N_ESTAGIOS-1:0] chain;
    logic [CNT_W-1:0]      cnt;
    logic                  sync;
    logic                  level;
    logic                  rise;
    logic                  fall;
    logic                  differs;
    logic                  accept;

    // Oldest flop of the chain is the only one safe to use downstream.
    assign sync    = chain[N_ESTAGIOS-1];
    assign differs = (sync != level);
    // cnt reaching CNT_MAX while still different means the new level has
    // been seen for DEBOUNCE_CICLOS consecutive edges, this one included.
    assign accept  = differs && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        chain <= {N_ESTAGIOS{VALOR_RESET[c]}};
        cnt   <= '0;
        level <= VALOR_RESET[c];
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        // Synchroniser stage: shift the raw input in at bit 0.
        chain <= {chain[N_ESTAGIOS-2:0], signal_in[c]};

        // Debounce stage: any return to the current level drops the count,
        // so partial credit is never kept; acceptance also clears it,
        // which keeps the counter from ever wrapping.
        if (!differs || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end

        if (accept) begin
          level <= sync;
        end

        // Edge stage: pulses are registered with the level update so they
        // line up with the new signal_out value and last one cycle.
        rise <= accept &&  sync;
        fall <= accept && !sync;
      end
    end

    assign signal_out[c] = level;
    assign rise_pulse[c] = rise;
    assign fall_pulse[c] = fall;
  end

endmodule
